// File: rtl/fwd_pkg.sv
// ============================================================================
// Module  : fwd_pkg
// Brief   : Shared forward-select codes and scoreboard entry type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

  localparam int FWD_SEL_RF  = 0;
  localparam int FWD_SEL_MEM = 1;
  localparam int FWD_SEL_WB  = 2;

  // Widest supported register address; narrower addresses are zero-extended.
  localparam int FWD_RD_MAXW = 8;

  typedef struct packed {
    logic                   valid;
    logic [FWD_RD_MAXW-1:0] rd;
    logic                   is_load;
  } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module  : fwd_match
// Brief   : Youngest-match priority encoder of one source against the
//           forwardable scoreboard entries; returns {hit, sel, is_load}.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_ENT = 2,
  parameter int SEL_W   = 2
) (
  input  sb_entry_t [NUM_ENT-1:0] ent_i,
  input  logic [REG_AW-1:0]       src_i,
  input  logic                    used_i,
  output logic                    hit_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    is_load_o
);

  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    hit_o     = 1'b0;
    sel_o     = '0;
    is_load_o = 1'b0;
    if (used_i && (src_i != '0)) begin
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
        if (ent_i[i].valid && (ent_i[i].rd == FWD_RD_MAXW'(src_i))) begin
          hit_o     = 1'b1;
          sel_o     = SEL_W'(i + 1);
          is_load_o = ent_i[i].is_load;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module  : fwd_scoreboard
// Brief   : Operand-forwarding and load-use hazard unit between ID and EX.
//           Optional stall statistics counter enabled by FWD_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_STG = 2,
  localparam int SEL_W   = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      pipe_en_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic                      id_we_i,
  input  logic                      id_is_load_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]               stall_count_o
`endif
);

  sb_entry_t [DEPTH-1:0]      sb_q, sb_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0]   w_cand_sel;
  logic [NUM_SRC-1:0]         w_hit, w_is_load, w_hazard;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_match #(
        .REG_AW  (REG_AW),
        .NUM_ENT (DEPTH - 1),
        .SEL_W   (SEL_W)
      ) u_match (
        .ent_i     (sb_q[DEPTH-2:0]),
        .src_i     (id_src_i[k*REG_AW +: REG_AW]),
        .used_i    (id_src_used_i[k]),
        .hit_o     (w_hit[k]),
        .sel_o     (w_cand_sel[k*SEL_W +: SEL_W]),
        .is_load_o (w_is_load[k])
      );
      // Load data not yet available at the stage the consumer would read it.
      assign w_hazard[k] = w_hit[k] & w_is_load[k] &
                           (32'(w_cand_sel[k*SEL_W +: SEL_W]) < LOAD_STG);
    end
  endgenerate

  assign stall_o   = id_valid_i & ~flush_i & (|w_hazard);
  assign fwd_sel_o = fwd_sel_q;

  always_comb begin
    sb_d      = sb_q;
    fwd_sel_d = fwd_sel_q;
    if (pipe_en_i) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      if (flush_i || stall_o) begin
        sb_d[0]   = '0;
        fwd_sel_d = '0;
      end else begin
        sb_d[0].valid   = id_valid_i & id_we_i & (id_rd_i != '0);
        sb_d[0].rd      = FWD_RD_MAXW'(id_rd_i);
        sb_d[0].is_load = id_is_load_i;
        fwd_sel_d       = w_cand_sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sb_q      <= '0;
      fwd_sel_q <= '0;
    end else begin
      sb_q      <= sb_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_count_q <= '0;
    end else if (pipe_en_i && stall_o && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count_o = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
// Module  : tb_fwd_scoreboard
// Brief   : Directed self-checking bench for fwd_scoreboard (default params).
//           Counter checks compile only when FWD_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fwd_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        pipe_en_i;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_we_i;
  logic        id_is_load_i;
  logic [4:0]  id_rd_i;
  logic [9:0]  id_src_i;
  logic [1:0]  id_src_used_i;
  logic        stall_o;
  logic [3:0]  fwd_sel_o;
`ifdef FWD_STATS_EN
  logic [15:0] stall_count_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  fwd_scoreboard dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pipe_en_i     (pipe_en_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_we_i       (id_we_i),
    .id_is_load_i  (id_is_load_i),
    .id_rd_i       (id_rd_i),
    .id_src_i      (id_src_i),
    .id_src_used_i (id_src_used_i),
    .stall_o       (stall_o),
    .fwd_sel_o     (fwd_sel_o)
`ifdef FWD_STATS_EN
    ,
    .stall_count_o (stall_count_o)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input logic ld,
                        input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used);
    id_valid_i    = v;
    id_we_i       = we;
    id_is_load_i  = ld;
    id_rd_i       = rd;
    id_src_i      = {s1, s0};
    id_src_used_i = used;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; pipe_en_i = 1'b1; flush_i = 1'b0;
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    repeat (2) step();
    rst_n_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
    total++; if (fwd_sel_o !== 4'h0) $display("FAIL reset_fwd: got %h want 0", fwd_sel_o); else passed++;
`ifdef FWD_STATS_EN
    total++; if (stall_count_o !== 16'h0) $display("FAIL reset_cnt: got %h want 0", stall_count_o); else passed++;
`endif
  endtask

  task automatic test_fwd_ex();
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b11);   // add r3,r1,r2
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd5, 2'b11);   // sub r4,r3,r5
    total++; if (stall_o !== 1'b0) $display("FAIL ex_stall: got %b want 0", stall_o); else passed++;
    step();
    total++; if (fwd_sel_o !== 4'b0001) $display("FAIL ex_fwd: got %b want 0001", fwd_sel_o); else passed++;
    idle(3);
  endtask

  task automatic test_fwd_wb_youngest();
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b11);   // add r3
    step();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);   // nop
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd7, 5'd3, 2'b11);   // or r6,r7,r3
    step();
    total++; if (fwd_sel_o !== 4'b1000) $display("FAIL wb_fwd: got %b want 1000", fwd_sel_o); else passed++;
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b11);   // add r3
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd9, 5'd10, 2'b11);  // add r3,r9,r10
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd11, 5'd3, 5'd3, 2'b11);  // reader of r3 twice
    step();
    total++; if (fwd_sel_o !== 4'b0101) $display("FAIL youngest_fwd: got %b want 0101", fwd_sel_o); else passed++;
    idle(3);
  endtask

  task automatic test_load_use();
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 2'b01);   // lw r2,0(r1)
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd2, 2'b11);   // add r8,r2,r2
    total++; if (stall_o !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_o); else passed++;
    step();
    total++; if (fwd_sel_o !== 4'b0000) $display("FAIL lu_bubble: got %b want 0000", fwd_sel_o); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL lu_release: got %b want 0", stall_o); else passed++;
    step();
    total++; if (fwd_sel_o !== 4'b1010) $display("FAIL lu_fwd: got %b want 1010", fwd_sel_o); else passed++;
`ifdef FWD_STATS_EN
    total++; if (stall_count_o !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stall_count_o); else passed++;
`endif
    idle(3);
  endtask

  task automatic test_r0_unused();
    set_id(1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 2'b01);   // load to r0
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 2'b11);   // reads r0 twice
    total++; if (stall_o !== 1'b0) $display("FAIL r0_stall: got %b want 0", stall_o); else passed++;
    step();
    total++; if (fwd_sel_o !== 4'b0000) $display("FAIL r0_fwd: got %b want 0000", fwd_sel_o); else passed++;
    idle(3);
    set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 2'b11);   // add r5
    step();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b00);   // r5 named, unused
    step();
    total++; if (fwd_sel_o !== 4'b0000) $display("FAIL unused_fwd: got %b want 0000", fwd_sel_o); else passed++;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b10);   // only src1 used
    step();
    total++; if (fwd_sel_o !== 4'b1000) $display("FAIL used1_fwd: got %b want 1000", fwd_sel_o); else passed++;
    idle(3);
  endtask

  task automatic test_freeze_flush();
    set_id(1'b1, 1'b1, 1'b0, 5'd1, 5'd4, 5'd5, 2'b11);   // add r1
    step();
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 2'b01);   // lw r2,0(r1)
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd2, 2'b11);   // add r8,r2,r2
    total++; if (stall_o !== 1'b1) $display("FAIL frz_stall0: got %b want 1", stall_o); else passed++;
    pipe_en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (stall_o !== 1'b1) $display("FAIL frz_stall c%0d: got %b want 1", c, stall_o); else passed++;
      total++; if (fwd_sel_o !== 4'b0001) $display("FAIL frz_fwd c%0d: got %b want 0001", c, fwd_sel_o); else passed++;
    end
`ifdef FWD_STATS_EN
    total++; if (stall_count_o !== 16'd1) $display("FAIL frz_cnt: got %0d want 1", stall_count_o); else passed++;
`endif
    pipe_en_i = 1'b1;
    flush_i   = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_o); else passed++;
    step();
    total++; if (fwd_sel_o !== 4'b0000) $display("FAIL flush_fwd: got %b want 0000", fwd_sel_o); else passed++;
`ifdef FWD_STATS_EN
    total++; if (stall_count_o !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", stall_count_o); else passed++;
`endif
    flush_i = 1'b0;
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 2'b01);   // lw r2
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd2, 2'b11);   // add r8,r2,r2
    total++; if (stall_o !== 1'b1) $display("FAIL rst_pre_stall: got %b want 1", stall_o); else passed++;
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else passed++;
    total++; if (fwd_sel_o !== 4'b0000) $display("FAIL rst_fwd: got %b want 0000", fwd_sel_o); else passed++;
`ifdef FWD_STATS_EN
    total++; if (stall_count_o !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", stall_count_o); else passed++;
`endif
    idle(3);
  endtask

`ifdef FWD_STATS_EN
  task automatic test_saturate();
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 2'b01);
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd2, 2'b11);
    pipe_en_i = 1'b0;
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    pipe_en_i = 1'b1;
    step();
    total++; if (stall_count_o !== 16'hFFFF) $display("FAIL sat_reach: got %h want FFFF", stall_count_o); else passed++;
    step();
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 2'b01);
    step();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd2, 2'b11);
    step();
    total++; if (stall_count_o !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", stall_count_o); else passed++;
    idle(3);
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_wb_youngest();
    test_load_use();
    test_r0_unused();
    test_freeze_flush();
    test_reset_mid_stall();
`ifdef FWD_STATS_EN
    test_saturate();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
